// File: rtl/pp_accumulator8.sv
// ============================================================================
// Module      : pp_accumulator8
// Description : Sequential 8x8 unsigned shift-and-add multiplier. It folds one
//               products8 partial-product row into a 16-bit product per clock.
//               Optional build macro: PPACC_ZERO_SKIP_EN (zero-operand bypass).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module products8 (
  input  logic [7:0] in1,
  input  logic       in2,
  output logic [7:0] pp
);

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_row
      assign pp[gi] = in1[gi] & in2;
    end
  endgenerate

endmodule

module pp_accumulator8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);

  // One-hot encoding lets each handshake output be a single state flop.
  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_RUN  = 3'b010,
    ST_DONE = 3'b100
  } state_t;

  localparam logic [2:0] c_last_iter = 3'd7;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_a;
  logic [15:0] r_p;
  logic [2:0]  r_cnt;
  logic [15:0] r_product;
  logic [7:0]  w_pp;
  logic [8:0]  w_sum9;
  logic [15:0] w_p_nxt;
  logic        w_accept;
  logic        w_zero_op;

  products8 u_products8 (
    .in1 (r_a),
    .in2 (r_p[0]),
    .pp  (w_pp)
  );

  assign w_sum9   = {1'b0, r_p[15:8]} + {1'b0, w_pp};
  assign w_p_nxt  = {w_sum9, r_p[7:1]};
  assign w_accept = (r_state == ST_IDLE) && start;

`ifdef PPACC_ZERO_SKIP_EN
  assign w_zero_op = (a == 8'd0) || (b == 8'd0);
`else
  assign w_zero_op = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = w_zero_op ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_cnt == c_last_iter) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= 8'd0;
      r_p       <= 16'd0;
      r_cnt     <= 3'd0;
      r_product <= 16'd0;
    end else begin
      if (w_accept) begin
        r_a   <= a;
        r_p   <= {8'd0, b};
        r_cnt <= 3'd0;
        if (w_zero_op) begin
          r_product <= 16'd0;
        end
      end else if (r_state == ST_RUN) begin
        r_p   <= w_p_nxt;
        r_cnt <= r_cnt + 3'd1;
        if (r_cnt == c_last_iter) begin
          r_product <= w_p_nxt;
        end
      end
    end
  end

  assign ready   = r_state[0];
  assign busy    = r_state[1];
  assign done    = r_state[2];
  assign product = r_product;

endmodule

`default_nettype wire

// File: tb/tb_pp_accumulator8.sv
// ============================================================================
// Module      : tb_pp_accumulator8
// Description : Directed self-checking bench for pp_accumulator8.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pp_accumulator8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pp_accumulator8 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  // Presents an operand pair so the next rising edge is E0; returns 1ns after E0.
  task automatic accept(input logic [7:0] av, input logic [7:0] bv);
    @(negedge clk);
    start = 1'b1;
    a     = av;
    b     = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({ready, busy, done} !== 3'b100) begin
      n_err++;
      $display("FAIL reset_asserted_flags got %b exp 100", {ready, busy, done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if ({ready, busy, done} !== 3'b100) begin
        n_err++;
        $display("FAIL reset_flags cyc%0d got %b exp 100", i, {ready, busy, done});
      end
      n_cmp++;
      if (product !== 16'h0000) begin
        n_err++;
        $display("FAIL reset_product cyc%0d got %h exp 0000", i, product);
      end
    end
  endtask

  task automatic test_single();
    accept(8'd13, 8'd11);
    for (int k = 0; k <= 10; k++) begin
      logic [2:0]  exp_f;
      logic [15:0] exp_p;
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      exp_f = (k < 8) ? 3'b010 : (k == 8) ? 3'b001 : 3'b100;
      exp_p = (k < 8) ? 16'h0000 : 16'h008F;
      n_cmp++;
      if ({ready, busy, done} !== exp_f) begin
        n_err++;
        $display("FAIL single_flags E%0d got %b exp %b", k, {ready, busy, done}, exp_f);
      end
      n_cmp++;
      if (product !== exp_p) begin
        n_err++;
        $display("FAIL single_product E%0d got %h exp %h", k, product, exp_p);
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'hFF;
    @(posedge clk);
    #1;
    a = 8'h80;
    b = 8'h02;
    for (int k = 1; k <= 19; k++) begin
      logic [2:0]  exp_f;
      logic [15:0] exp_p;
      @(posedge clk);
      #1;
      if (k == 18) start = 1'b0;
      if (k < 8)       begin exp_f = 3'b010; exp_p = 16'h008F; end
      else if (k == 8) begin exp_f = 3'b001; exp_p = 16'hFE01; end
      else if (k == 9) begin exp_f = 3'b100; exp_p = 16'hFE01; end
      else if (k < 18) begin exp_f = 3'b010; exp_p = 16'hFE01; end
      else if (k == 18) begin exp_f = 3'b001; exp_p = 16'h0100; end
      else             begin exp_f = 3'b100; exp_p = 16'h0100; end
      n_cmp++;
      if ({ready, busy, done} !== exp_f) begin
        n_err++;
        $display("FAIL b2b_flags E%0d got %b exp %b", k, {ready, busy, done}, exp_f);
      end
      n_cmp++;
      if (product !== exp_p) begin
        n_err++;
        $display("FAIL b2b_product E%0d got %h exp %h", k, product, exp_p);
      end
    end
  endtask

  task automatic test_ignore_start();
    accept(8'h12, 8'h34);
    for (int k = 1; k <= 10; k++) begin
      logic [2:0]  exp_f;
      logic [15:0] exp_p;
      @(posedge clk);
      #1;
      if (k == 2) begin
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
      end
      if (k == 3) start = 1'b0;
      if (k < 8)       begin exp_f = 3'b010; exp_p = 16'h0100; end
      else if (k == 8) begin exp_f = 3'b001; exp_p = 16'h03A8; end
      else             begin exp_f = 3'b100; exp_p = 16'h03A8; end
      n_cmp++;
      if ({ready, busy, done} !== exp_f) begin
        n_err++;
        $display("FAIL ignore_flags E%0d got %b exp %b", k, {ready, busy, done}, exp_f);
      end
      n_cmp++;
      if (product !== exp_p) begin
        n_err++;
        $display("FAIL ignore_product E%0d got %h exp %h", k, product, exp_p);
      end
    end
  endtask

  task automatic test_async_reset();
    accept(8'hAA, 8'h55);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (busy !== 1'b1) begin
        n_err++;
        $display("FAIL abort_busy E%0d got %b exp 1", k, busy);
      end
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ready, busy, done} !== 3'b100) begin
      n_err++;
      $display("FAIL abort_flags got %b exp 100", {ready, busy, done});
    end
    n_cmp++;
    if (product !== 16'h0000) begin
      n_err++;
      $display("FAIL abort_product got %h exp 0000", product);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if ({ready, busy, done} !== 3'b100) begin
        n_err++;
        $display("FAIL abort_nodone cyc%0d got %b exp 100", k, {ready, busy, done});
      end
    end
    accept(8'h03, 8'h05);
    for (int k = 1; k <= 9; k++) begin
      logic [2:0]  exp_f;
      logic [15:0] exp_p;
      @(posedge clk);
      #1;
      exp_f = (k < 8) ? 3'b010 : (k == 8) ? 3'b001 : 3'b100;
      exp_p = (k < 8) ? 16'h0000 : 16'h000F;
      n_cmp++;
      if ({ready, busy, done} !== exp_f) begin
        n_err++;
        $display("FAIL fresh_flags E%0d got %b exp %b", k, {ready, busy, done}, exp_f);
      end
      n_cmp++;
      if (product !== exp_p) begin
        n_err++;
        $display("FAIL fresh_product E%0d got %h exp %h", k, product, exp_p);
      end
    end
  endtask

  task automatic test_zero();
`ifdef PPACC_ZERO_SKIP_EN
    accept(8'h00, 8'h7F);
    n_cmp++;
    if ({ready, busy, done} !== 3'b001) begin
      n_err++;
      $display("FAIL zero_skip_flags E0 got %b exp 001", {ready, busy, done});
    end
    n_cmp++;
    if (product !== 16'h0000) begin
      n_err++;
      $display("FAIL zero_skip_product E0 got %h exp 0000", product);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({ready, busy, done} !== 3'b100) begin
      n_err++;
      $display("FAIL zero_skip_flags E1 got %b exp 100", {ready, busy, done});
    end
`else
    accept(8'h00, 8'h7F);
    for (int k = 1; k <= 9; k++) begin
      logic [2:0]  exp_f;
      logic [15:0] exp_p;
      @(posedge clk);
      #1;
      exp_f = (k < 8) ? 3'b010 : (k == 8) ? 3'b001 : 3'b100;
      exp_p = (k < 8) ? 16'h000F : 16'h0000;
      n_cmp++;
      if ({ready, busy, done} !== exp_f) begin
        n_err++;
        $display("FAIL zero_flags E%0d got %b exp %b", k, {ready, busy, done}, exp_f);
      end
      n_cmp++;
      if (product !== exp_p) begin
        n_err++;
        $display("FAIL zero_product E%0d got %h exp %h", k, product, exp_p);
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore_start();
    test_async_reset();
    test_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pp_accumulator8.md
# pp_accumulator8

Sequential 8x8 unsigned shift-and-add multiplier that consumes the 8-bit partial-product rows produced by the `products8` row generator (multiplicand AND one multiplier bit). It accumulates one row per clock into a 16-bit product. It sits directly downstream of the row generator in the FPU mantissa-multiply path, and exposes a start/ready/done handshake to the control FSM.

## Interface
- No parameters; widths fixed at 8-bit operands, 16-bit product.
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only when `ready`=1.
- `a`  in  8  multiplicand, captured on an accepted `start`.
- `b`  in  8  multiplier, captured on an accepted `start`.
- `ready`  out  1  high in IDLE only.
- `busy`  out  1  high in RUN only.
- `done`  out  1  one-cycle pulse, high in DONE only.
- `product`  out  16  registered result; holds last completed value.

## Operation
- Internal state:
  - 8-bit `A` (latched multiplicand).
  - 16-bit `P` = {`H`[7:0], `L`[7:0]}.
  - 3-bit iteration counter `cnt`.
  - FSM state.
- FSM states IDLE, RUN, DONE.
  - IDLE: on `start`=1, latch `A`=`a`, `H`=0, `L`=`b`, `cnt`=0, then go to RUN. With `start`=0, stay in IDLE.
  - RUN: each cycle, drive `products8` with `in1`=`A`, `in2`=`L[0]` to get `pp`[7:0].
    - Compute `sum9` = {1'b0,`H`} + {1'b0,`pp`} (9-bit, no overflow lost).
    - Update `P` <= {`sum9`[8:0], `L`[7:1]}.
    - `cnt` <= `cnt`+1.
    - On the iteration with `cnt`=7: load `product` <= new `P` and go to DONE.
  - DONE: `done`=1 for exactly one cycle, then go to IDLE unconditionally.
- `start` is ignored in RUN and DONE; there is no queuing. `a` and `b` are don't-care outside an accepted start.
- `product` changes only on the completion edge. During RUN it still shows the previous result.
- Arithmetic: unsigned only. Result = `a`×`b` exactly, maximum 0xFE01.
- Reset, asynchronous at any time including mid-RUN:
  - State returns to IDLE; `A`, `P`, `cnt` cleared.
  - `product`=0x0000, `ready`=1, `busy`=0, `done`=0.
  - An aborted operation never produces `done`.

## Timing
- Let E0 be the rising edge that samples `start`=1 with `ready`=1.
  - Edges E1..E8 perform iterations 0..7.
  - E8 loads `product` and enters DONE.
  - `done`=1 between E8 and E9.
  - E9 returns to IDLE.
- Latency from accept to `done`: 8 cycles. `product` is valid from E8 onward.
- Issue period with `start` held high: 10 cycles. The next accept occurs at E10.
- `ready`, `busy`, `done` are mutually exclusive and decode directly from registered state. They are glitch-free and not combinational on `start`.

## Configuration
- Macro: `PPACC_ZERO_SKIP_EN`.
- Defined:
  - At IDLE accept, if `a`==0 or `b`==0, the FSM goes IDLE→DONE at E0 and loads `product`=0x0000 at E0.
  - `done`=1 between E0 and E1, giving 1-cycle latency.
  - Nonzero operands behave exactly as undefined.
- Undefined: every operation runs the full 8 iterations, including zero operands (`done` after E8, `product`=0).

## Test plan
- Reset release, no start → `ready`=1, `busy`=0, `done`=0, `product`=0x0000 held indefinitely.
- `a`=13, `b`=11, single start → `busy` for E1..E8, `done` pulse after E8, `product`=0x008F. `product` holds 0x008F after `done` falls.
- `a`=0xFF, `b`=0xFF, then `a`=0x80, `b`=0x02 with `start` held high → `product`=0xFE01 (`done` after E8), then `product`=0x0100 (`done` 10 cycles later). Starts during RUN/DONE are ignored.
- Start with 0x12×0x34, reassert `start` with other operands at E3 → ignored, `product`=0x03A8.
- `rst_n` low at E4 of a 0xAA×0x55 operation → immediate IDLE, `product`=0x0000, no `done`. A fresh 0x03×0x05 then yields 0x000F after 8 cycles.
- `a`=0x00, `b`=0x7F: with `PPACC_ZERO_SKIP_EN` → `done` after E0, `product`=0x0000. Without it → `done` after E8, `product`=0x0000.
